// File: rtl/adder_reservation_station.sv
// adder_reservation_station: reservation station for the CLA add/sub unit.
// Buffers dispatched add/sub ops, snoops the CDB for missing operands and
// issues at most one ready op per cycle into registered FU_* outputs.
// Ports:
//   clk, rst (async, active-low)
//   VALID_Inst, ROBEN, operation, Qj/Qk, Vj/Vk : dispatch request
//   CDB_ROBEN, CDB_Write_Data                  : common data bus snoop
//   FU_stall                                   : hold issue registers
//   FLUSH (only with RS_FLUSH_EN defined)      : sync clear of all entries
//   FULL_FLAG                                  : all entries busy
//   FU_ROBEN, FU_operand1/2, FU_operation      : issued op (ROBEN 0 = bubble)
// Optional feature macro: RS_FLUSH_EN
module adder_reservation_station #(
   parameter int ENTRIES = 4,
   parameter int ROBEN_W = 5,
   parameter int DATA_W  = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               VALID_Inst,
   input  logic [ROBEN_W-1:0] ROBEN,
   input  logic               operation,
   input  logic [ROBEN_W-1:0] Qj,
   input  logic [ROBEN_W-1:0] Qk,
   input  logic [DATA_W-1:0]  Vj,
   input  logic [DATA_W-1:0]  Vk,
   input  logic [ROBEN_W-1:0] CDB_ROBEN,
   input  logic [DATA_W-1:0]  CDB_Write_Data,
   input  logic               FU_stall,
`ifdef RS_FLUSH_EN
   input  logic               FLUSH,
`endif
   output logic               FULL_FLAG,
   output logic [ROBEN_W-1:0] FU_ROBEN,
   output logic [DATA_W-1:0]  FU_operand1,
   output logic [DATA_W-1:0]  FU_operand2,
   output logic               FU_operation
);
   localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   logic [ENTRIES-1:0]              busy_q, busy_d, op_q, op_d, rdy;
   logic [ENTRIES-1:0][ROBEN_W-1:0] rob_q, rob_d, qj_q, qj_d, qk_q, qk_d;
   logic [ENTRIES-1:0][DATA_W-1:0]  vj_q, vj_d, vk_q, vk_d;
   logic [ROBEN_W-1:0]              fu_rob_q, fu_rob_d;
   logic [DATA_W-1:0]               fu_op1_q, fu_op1_d, fu_op2_q, fu_op2_d;
   logic                            fu_sel_q, fu_sel_d;
   logic [IW-1:0]                   free_idx, rdy_idx;
   logic                            rdy_any, cdb_v, flush, disp, cap_j, cap_k;
   assign cdb_v     = CDB_ROBEN != '0;
   assign FULL_FLAG = &busy_q;
   assign disp      = VALID_Inst && !FULL_FLAG;
   // operands already waiting on the tag being broadcast this cycle
   assign cap_j     = cdb_v && Qj == CDB_ROBEN;
   assign cap_k     = cdb_v && Qk == CDB_ROBEN;
`ifdef RS_FLUSH_EN
   assign flush     = FLUSH;
`else
   assign flush     = 1'b0;
`endif
   assign FU_ROBEN     = fu_rob_q;
   assign FU_operand1  = fu_op1_q;
   assign FU_operand2  = fu_op2_q;
   assign FU_operation = fu_sel_q;
   // downward scan so the last hit is the lowest index
   always_comb begin
      rdy      = '0;
      free_idx = '0;
      rdy_idx  = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         rdy[i] = busy_q[i] && qj_q[i] == '0 && qk_q[i] == '0;
         if (!busy_q[i]) free_idx = IW'(i);
         if (rdy[i]) rdy_idx = IW'(i);
      end
      rdy_any = |rdy;
   end
   always_comb begin
      busy_d   = busy_q;
      rob_d    = rob_q;
      op_d     = op_q;
      qj_d     = qj_q;
      qk_d     = qk_q;
      vj_d     = vj_q;
      vk_d     = vk_q;
      fu_rob_d = fu_rob_q;
      fu_op1_d = fu_op1_q;
      fu_op2_d = fu_op2_q;
      fu_sel_d = fu_sel_q;
      for (int i = 0; i < ENTRIES; i++) begin
         if (busy_q[i] && cdb_v && qj_q[i] == CDB_ROBEN) begin
            vj_d[i] = CDB_Write_Data;
            qj_d[i] = '0;
         end
         if (busy_q[i] && cdb_v && qk_q[i] == CDB_ROBEN) begin
            vk_d[i] = CDB_Write_Data;
            qk_d[i] = '0;
         end
      end
      if (disp) begin
         busy_d[free_idx] = 1'b1;
         rob_d[free_idx]  = ROBEN;
         op_d[free_idx]   = operation;
         qj_d[free_idx]   = cap_j ? '0 : Qj;
         vj_d[free_idx]   = cap_j ? CDB_Write_Data : Vj;
         qk_d[free_idx]   = cap_k ? '0 : Qk;
         vk_d[free_idx]   = cap_k ? CDB_Write_Data : Vk;
      end
      // a dispatched entry is never busy pre-edge, so it cannot collide with issue
      if (!FU_stall) begin
         fu_rob_d = rdy_any ? rob_q[rdy_idx] : '0;
         fu_op1_d = rdy_any ? vj_q[rdy_idx] : fu_op1_q;
         fu_op2_d = rdy_any ? vk_q[rdy_idx] : fu_op2_q;
         fu_sel_d = rdy_any ? op_q[rdy_idx] : fu_sel_q;
         if (rdy_any) busy_d[rdy_idx] = 1'b0;
      end
      if (flush) begin
         busy_d   = '0;
         fu_rob_d = '0;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q   <= '0;
         rob_q    <= '0;
         op_q     <= '0;
         qj_q     <= '0;
         qk_q     <= '0;
         vj_q     <= '0;
         vk_q     <= '0;
         fu_rob_q <= '0;
         fu_op1_q <= '0;
         fu_op2_q <= '0;
         fu_sel_q <= 1'b0;
      end else begin
         busy_q   <= busy_d;
         rob_q    <= rob_d;
         op_q     <= op_d;
         qj_q     <= qj_d;
         qk_q     <= qk_d;
         vj_q     <= vj_d;
         vk_q     <= vk_d;
         fu_rob_q <= fu_rob_d;
         fu_op1_q <= fu_op1_d;
         fu_op2_q <= fu_op2_d;
         fu_sel_q <= fu_sel_d;
      end
   end
endmodule

// File: tb/tb_adder_reservation_station.sv
// tb_adder_reservation_station: directed self-checking bench for the add/sub reservation station.
module tb_adder_reservation_station;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        VALID_Inst = 1'b0;
   logic [4:0]  ROBEN = '0;
   logic        operation = 1'b0;
   logic [4:0]  Qj = '0, Qk = '0;
   logic [31:0] Vj = '0, Vk = '0;
   logic [4:0]  CDB_ROBEN = '0;
   logic [31:0] CDB_Write_Data = '0;
   logic        FU_stall = 1'b0;
`ifdef RS_FLUSH_EN
   logic        FLUSH = 1'b0;
`endif
   logic        FULL_FLAG;
   logic [4:0]  FU_ROBEN;
   logic [31:0] FU_operand1, FU_operand2;
   logic        FU_operation;
   int          tests = 0;
   int          fails = 0;
   adder_reservation_station dut (
      .clk(clk), .rst(rst), .VALID_Inst(VALID_Inst), .ROBEN(ROBEN),
      .operation(operation), .Qj(Qj), .Qk(Qk), .Vj(Vj), .Vk(Vk),
      .CDB_ROBEN(CDB_ROBEN), .CDB_Write_Data(CDB_Write_Data), .FU_stall(FU_stall),
`ifdef RS_FLUSH_EN
      .FLUSH(FLUSH),
`endif
      .FULL_FLAG(FULL_FLAG), .FU_ROBEN(FU_ROBEN), .FU_operand1(FU_operand1),
      .FU_operand2(FU_operand2), .FU_operation(FU_operation)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic disp(input logic [4:0] rob, input logic [4:0] qj, input logic [31:0] vj,
                       input logic [4:0] qk, input logic [31:0] vk, input logic op);
      VALID_Inst = 1'b1;
      ROBEN = rob; Qj = qj; Vj = vj; Qk = qk; Vk = vk; operation = op;
      tick();
      VALID_Inst = 1'b0;
   endtask
   task automatic fu(input string tag, input logic [4:0] rob, input logic [31:0] a,
                     input logic [31:0] b, input logic op);
      chk({tag, "_rob"}, 32'(FU_ROBEN), 32'(rob));
      chk({tag, "_op1"}, FU_operand1, a);
      chk({tag, "_op2"}, FU_operand2, b);
      chk({tag, "_sel"}, 32'(FU_operation), 32'(op));
   endtask
   initial begin
      #12;
      chk("rst_full", 32'(FULL_FLAG), 0);
      fu("rst", 5'd0, 32'h0, 32'h0, 1'b0);
      rst = 1'b1;
      tick();
      // ready at dispatch: visible one edge after dispatch, not earlier
      disp(5'd4, 5'd0, 32'h0AAAA34A, 5'd0, 32'h14, 1'b0);
      chk("rdy_nobypass", 32'(FU_ROBEN), 0);
      tick();
      fu("rdy", 5'd4, 32'h0AAAA34A, 32'h14, 1'b0);
      tick();
      fu("bubble_hold", 5'd0, 32'h0AAAA34A, 32'h14, 1'b0);
      // CDB wakeup of operand1
      disp(5'd2, 5'd7, 32'h0, 5'd0, 32'h5, 1'b1);
      chk("wk_wait0", 32'(FU_ROBEN), 0);
      tick();
      chk("wk_wait1", 32'(FU_ROBEN), 0);
      CDB_ROBEN = 5'd7; CDB_Write_Data = 32'h1A;
      tick();
      CDB_ROBEN = '0; CDB_Write_Data = '0;
      chk("wk_cdb_edge", 32'(FU_ROBEN), 0);
      tick();
      fu("wk", 5'd2, 32'h1A, 32'h5, 1'b1);
      // both operands captured from the CDB in the dispatch cycle
      CDB_ROBEN = 5'd9; CDB_Write_Data = 32'hBC;
      disp(5'd6, 5'd9, 32'h0, 5'd9, 32'h0, 1'b0);
      CDB_ROBEN = '0; CDB_Write_Data = '0;
      tick();
      fu("cap", 5'd6, 32'hBC, 32'hBC, 1'b0);
      tick();
      chk("cap_drain", 32'(FU_ROBEN), 0);
      // fill, drop when full, in-order issue
      for (int i = 1; i <= 4; i++) begin
         chk("fill_notfull", 32'(FULL_FLAG), 0);
         disp(5'(i), 5'd3, 32'h0, 5'd0, 32'h100 + 32'(i), 1'b1);
      end
      chk("fill_full", 32'(FULL_FLAG), 1);
      disp(5'd5, 5'd0, 32'h77, 5'd0, 32'h88, 1'b0);
      chk("drop_full", 32'(FULL_FLAG), 1);
      chk("drop_noissue", 32'(FU_ROBEN), 0);
      CDB_ROBEN = 5'd3; CDB_Write_Data = 32'h33;
      tick();
      CDB_ROBEN = '0; CDB_Write_Data = '0;
      chk("order_wake", 32'(FU_ROBEN), 0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         fu("order", 5'(i), 32'h33, 32'h100 + 32'(i), 1'b1);
         chk("order_full", 32'(FULL_FLAG), 0);
      end
      tick();
      chk("order_end", 32'(FU_ROBEN), 0);
      // stall: issue registers freeze, ready entries stay busy
      FU_stall = 1'b1;
      disp(5'd10, 5'd0, 32'h11, 5'd0, 32'h22, 1'b0);
      disp(5'd11, 5'd0, 32'h33, 5'd0, 32'h44, 1'b1);
      disp(5'd12, 5'd20, 32'h0, 5'd0, 32'h66, 1'b0);
      disp(5'd13, 5'd20, 32'h0, 5'd0, 32'h77, 1'b1);
      chk("stall_full", 32'(FULL_FLAG), 1);
      fu("stall_hold", 5'd0, 32'h33, 32'h104, 1'b1);
      FU_stall = 1'b0;
      tick();
      fu("unstall0", 5'd10, 32'h11, 32'h22, 1'b0);
      chk("unstall_full", 32'(FULL_FLAG), 0);
      tick();
      fu("unstall1", 5'd11, 32'h33, 32'h44, 1'b1);
      tick();
      chk("unstall_idle", 32'(FU_ROBEN), 0);
`ifdef RS_FLUSH_EN
      FLUSH = 1'b1;
      tick();
      FLUSH = 1'b0;
      chk("flush_rob", 32'(FU_ROBEN), 0);
      CDB_ROBEN = 5'd20; CDB_Write_Data = 32'h55;
      tick();
      CDB_ROBEN = '0;
      tick();
      chk("flush_gone", 32'(FU_ROBEN), 0);
`else
      CDB_ROBEN = 5'd20; CDB_Write_Data = 32'h55;
      tick();
      CDB_ROBEN = '0;
      tick();
      fu("late0", 5'd12, 32'h55, 32'h66, 1'b0);
      tick();
      fu("late1", 5'd13, 32'h55, 32'h77, 1'b1);
`endif
      tick();
      // asynchronous reset with entries busy and a live issue
      disp(5'd15, 5'd0, 32'h1, 5'd0, 32'h2, 1'b0);
      disp(5'd16, 5'd30, 32'h0, 5'd0, 32'h0, 1'b0);
      fu("pre_rst", 5'd15, 32'h1, 32'h2, 1'b0);
      FU_stall = 1'b1;
      disp(5'd17, 5'd30, 32'h0, 5'd0, 32'h0, 1'b0);
      disp(5'd18, 5'd30, 32'h0, 5'd0, 32'h0, 1'b0);
      disp(5'd19, 5'd30, 32'h0, 5'd0, 32'h0, 1'b0);
      chk("pre_rst_full", 32'(FULL_FLAG), 1);
      chk("pre_rst_rob", 32'(FU_ROBEN), 15);
      #2 rst = 1'b0;
      #1;
      chk("arst_full", 32'(FULL_FLAG), 0);
      fu("arst", 5'd0, 32'h0, 32'h0, 1'b0);
      FU_stall = 1'b0;
      #3 rst = 1'b1;
      tick();
      chk("post_rst_rob", 32'(FU_ROBEN), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
